// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 8-bit RISC control sequencer: opcode values,
// sequencer state encoding, register-file write-data source encodings and
// ALU operation encodings, plus two small helpers used by the sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcode field values, taken from ir[7:4]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_FETCH2 = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Register-file write-data source select
  localparam logic [1:0] DIN_ALU = 2'd0;
  localparam logic [1:0] DIN_IMM = 2'd1;
  localparam logic [1:0] DIN_RS  = 2'd2;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Opcode field of an instruction byte
  function automatic logic [3:0] opcodeOf(input logic [7:0] ir);
    return ir[7:4];
  endfunction

  // True in the two states that run the instruction-memory handshake
  function automatic logic isFetchState(input logic [2:0] st);
    return (st == ST_FETCH) || (st == ST_FETCH2);
  endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// ---------------------------------------------------------------------------
// cpu_instr_decode
// Purely combinational opcode classifier for the control sequencer.
// Ports:
//   i_opcode       in  4  opcode field of the instruction register (ir[7:4])
//   o_is_alu       out 1  ADD/SUB/AND/OR/XOR (writes ALU result, updates zflag)
//   o_is_mov       out 1  MOV (register-to-register copy)
//   o_is_two_byte  out 1  LDI/JMP/JZ (need a second byte from memory)
//   o_is_halt      out 1  HLT
//   o_is_illegal   out 1  undefined opcodes A..E
//   o_alu_op       out 3  ALU operation for this opcode (pass when not ALU)
//   o_din_sel      out 2  register-file write-data source for this opcode
// ---------------------------------------------------------------------------
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_mov,
  output logic       o_is_two_byte,
  output logic       o_is_halt,
  output logic       o_is_illegal,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_din_sel
);

  // Opcode table. NOP falls through to the defaults: no write, pass-through
  // ALU and ALU data source, which are also the idle values seen by the
  // datapath outside of EXEC/WB.
  always_comb begin
    o_is_alu      = 1'b0;
    o_is_mov      = 1'b0;
    o_is_two_byte = 1'b0;
    o_is_halt     = 1'b0;
    o_is_illegal  = 1'b0;
    o_alu_op      = ALU_PASS;
    o_din_sel     = DIN_ALU;
    case (i_opcode)
      OP_ADD: begin
        o_is_alu = 1'b1;
        o_alu_op = ALU_ADD;
      end
      OP_SUB: begin
        o_is_alu = 1'b1;
        o_alu_op = ALU_SUB;
      end
      OP_AND: begin
        o_is_alu = 1'b1;
        o_alu_op = ALU_AND;
      end
      OP_OR: begin
        o_is_alu = 1'b1;
        o_alu_op = ALU_OR;
      end
      OP_XOR: begin
        o_is_alu = 1'b1;
        o_alu_op = ALU_XOR;
      end
      OP_MOV: begin
        o_is_mov  = 1'b1;
        o_din_sel = DIN_RS;
      end
      OP_LDI: begin
        o_is_two_byte = 1'b1;
        o_din_sel     = DIN_IMM;
      end
      OP_JMP, OP_JZ: begin
        o_is_two_byte = 1'b1;
      end
      OP_HLT: begin
        o_is_halt = 1'b1;
      end
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
        o_is_illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multi-cycle control sequencer for the 8-bit RISC core. Fetches one- and
// two-byte instructions over a req/ack handshake, decodes them and drives
// the register file, ALU and program counter.
// Parameters:
//   RESET_PC          PC value loaded on reset
// Ports:
//   clk         in  1  system clock, rising edge
//   rst_n       in  1  asynchronous active-low reset
//   run         in  1  enables new instruction-memory requests
//   imem_req    out 1  instruction-memory read request
//   imem_addr   out 8  read address (the pc)
//   imem_ack    in  1  read data valid this cycle
//   imem_data   in  8  instruction or immediate byte
//   rf_we       out 1  register-file write enable (single-cycle pulse)
//   rf_rd       out 2  destination / first operand register (ir[3:2])
//   rf_rs       out 2  source register (ir[1:0])
//   rf_din_sel  out 2  write-data source: 0 ALU, 1 imm, 2 rs value
//   alu_op      out 3  ALU operation (7 = pass)
//   alu_zero    in  1  ALU result-is-zero from the datapath
//   imm         out 8  latched immediate byte
//   zflag       out 1  registered zero flag
//   halted      out 1  high while halted
//   illegal     out 1  single-cycle pulse on an undefined opcode
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       rf_we,
  output logic [1:0] rf_rd,
  output logic [1:0] rf_rs,
  output logic [1:0] rf_din_sel,
  output logic [2:0] alu_op,
  input  logic       alu_zero,
  output logic [7:0] imm,
  output logic       zflag,
  output logic       halted,
  output logic       illegal
);

  logic [2:0] r_state;
  logic [2:0] w_stateNext;
  logic [7:0] r_pc;
  logic [7:0] w_pcNext;
  logic [7:0] r_ir;
  logic [7:0] r_imm;
  logic       r_zflag;

  logic [3:0] w_opcode;
  logic       w_isAlu;
  logic       w_isMov;
  logic       w_isTwoByte;
  logic       w_isHalt;
  logic       w_isIllegal;
  logic [2:0] w_aluOp;
  logic [1:0] w_dinSel;

  logic       w_req;
  logic       w_ack;
  logic       w_jumpTaken;

  assign w_opcode = opcodeOf(r_ir);

  cpu_instr_decode u_decode (
    .i_opcode      (w_opcode),
    .o_is_alu      (w_isAlu),
    .o_is_mov      (w_isMov),
    .o_is_two_byte (w_isTwoByte),
    .o_is_halt     (w_isHalt),
    .o_is_illegal  (w_isIllegal),
    .o_alu_op      (w_aluOp),
    .o_din_sel     (w_dinSel)
  );

  // The request is combinational on run so that dropping run withdraws an
  // outstanding request at once. rst_n is folded in because the state is
  // already FETCH while reset is held, and no request may escape then.
  assign w_req = rst_n & run & isFetchState(r_state);

  // Acks are only meaningful against a live request
  assign w_ack = w_req & imem_ack;

  // JMP always redirects; JZ only on a set zero flag. The target comes
  // straight off the memory bus in the ack cycle, not from r_imm.
  assign w_jumpTaken = (r_state == ST_FETCH2) &&
                       ((w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && r_zflag));

  // Next-state selection. Illegal opcodes and NOP return straight to FETCH;
  // HALT is only left through reset.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_ack) w_stateNext = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_isTwoByte)              w_stateNext = ST_FETCH2;
        else if (w_isHalt)            w_stateNext = ST_HALT;
        else if (w_isAlu || w_isMov)  w_stateNext = ST_EXEC;
        else                          w_stateNext = ST_FETCH;
      end
      ST_FETCH2: begin
        if (w_ack) w_stateNext = (w_opcode == OP_LDI) ? ST_WB : ST_FETCH;
      end
      ST_EXEC:  w_stateNext = ST_WB;
      ST_WB:    w_stateNext = ST_FETCH;
      ST_HALT:  w_stateNext = ST_HALT;
      default:  w_stateNext = ST_FETCH;
    endcase
  end

  // Program counter: one increment per accepted byte (8-bit wrap), or the
  // jump target when a jump resolves in FETCH2.
  always_comb begin
    w_pcNext = r_pc;
    if (w_ack) begin
      if (w_jumpTaken) w_pcNext = imem_data;
      else             w_pcNext = r_pc + 8'd1;
    end
  end

  // Sequencer registers. ir and imm load only in their ack cycle, so bus
  // contents during memory wait states never reach them. zflag follows the
  // ALU only for arithmetic/logic writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 8'h00;
      r_imm   <= 8'h00;
      r_zflag <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_ack && (r_state == ST_FETCH))  r_ir  <= imem_data;
      if (w_ack && (r_state == ST_FETCH2)) r_imm <= imem_data;
      if ((r_state == ST_WB) && w_isAlu)   r_zflag <= alu_zero;
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign rf_we      = (r_state == ST_WB);
  assign rf_rd      = r_ir[3:2];
  assign rf_rs      = r_ir[1:0];
  assign rf_din_sel = (r_state == ST_WB) ? w_dinSel : DIN_ALU;
  // alu_op is presented in EXEC and held through WB so the written result
  // is the one the ALU computed; elsewhere the ALU idles in pass mode.
  assign alu_op     = ((r_state == ST_EXEC) || (r_state == ST_WB)) ? w_aluOp : ALU_PASS;
  assign imm        = r_imm;
  assign zflag      = r_zflag;
  assign halted     = (r_state == ST_HALT);
  // DECODE lasts exactly one cycle, so this is a single-cycle pulse
  assign illegal    = (r_state == ST_DECODE) && w_isIllegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
// Bench for the control sequencer. The bench plays instruction memory and
// the ALU zero output, and keeps an instruction-level model of the program
// (pc, zero flag, expected register writes / illegal pulses per
// instruction) that every memory handshake and write pulse is held against.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic       rf_we;
  logic [1:0] rf_rd;
  logic [1:0] rf_rs;
  logic [1:0] rf_din_sel;
  logic [2:0] alu_op;
  logic       alu_zero = 1'b0;
  logic [7:0] imm;
  logic       zflag;
  logic       halted;
  logic       illegal;

  cpu_ctrl_fsm #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_rs      (rf_rs),
    .rf_din_sel (rf_din_sel),
    .alu_op     (alu_op),
    .alu_zero   (alu_zero),
    .imm        (imm),
    .zflag      (zflag),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  // memory / environment knobs
  int  waitFixed = 0;
  int  runPct = 100;
  int  azFixed = -1;
  bit  ackNoise = 1'b0;
  bit  latCheck = 1'b0;

  // memory responder state
  bit         pending = 1'b0;
  logic [7:0] pendAddr = 8'h00;
  int         waitLeft = 0;

  // instruction-level model
  logic [7:0] mPc = RESET_PC;
  logic       mZ = 1'b0;
  bit         expectImm = 1'b0;
  bit         haveCur = 1'b0;
  logic [7:0] curIns = 8'h00;
  logic       curAz = 1'b0;
  int         expWe = 0;
  int         expIll = 0;
  int         seenWe = 0;
  int         seenIll = 0;
  logic [1:0] expRd = 2'd0;
  logic [1:0] expSel = 2'd0;
  logic [2:0] expOp = 3'd7;
  bit         chkOp = 1'b0;
  logic [7:0] expImm = 8'h00;
  int         nInstr = 0;
  int         cycle = 0;
  int         lastFetchCycle = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Close out the previous instruction: write/illegal counts, zero flag,
  // and (in zero-wait runs) how many cycles it took.
  task automatic modelRetire();
    logic [3:0] op;
    int lat;
    if (haveCur) begin
      op = curIns[7:4];
      checkOutput("weCount", 32'(seenWe), 32'(expWe));
      checkOutput("illCount", 32'(seenIll), 32'(expIll));
      if (op >= 4'd1 && op <= 4'd5) mZ = curAz;
      checkOutput("zflag", 32'(zflag), 32'(mZ));
      if (latCheck && !(op >= 4'd7 && op <= 4'd9)) begin
        lat = (expWe != 0) ? 4 : 2;
        checkOutput("latency", 32'(cycle - lastFetchCycle), 32'(lat));
      end
    end
  endtask

  // Start a new instruction in the model from its first byte
  task automatic modelIssue(input logic [7:0] data);
    logic [3:0] op;
    op = data[7:4];
    curIns = data;
    mPc = mPc + 8'd1;
    haveCur = 1'b1;
    seenWe = 0;
    seenIll = 0;
    curAz = (azFixed >= 0) ? azFixed[0] : 1'($urandom_range(1));
    alu_zero = curAz;
    expWe = 0;
    expIll = 0;
    chkOp = 1'b0;
    expRd = data[3:2];
    expSel = 2'd0;
    expOp = 3'd7;
    if (op >= 4'd1 && op <= 4'd5) begin
      expWe = 1;
      expSel = 2'd0;
      chkOp = 1'b1;
      expOp = 3'(op - 4'd1);
    end else if (op == 4'd6) begin
      expWe = 1;
      expSel = 2'd2;
    end else if (op == 4'd7) begin
      expWe = 1;
      expSel = 2'd1;
    end else if (op >= 4'hA && op <= 4'hE) begin
      expIll = 1;
    end
    expectImm = (op >= 4'd7 && op <= 4'd9);
    lastFetchCycle = cycle;
    nInstr++;
  endtask

  task automatic handshake(input logic [7:0] addr, input logic [7:0] data);
    logic [3:0] op;
    if (expectImm) begin
      checkOutput("immAddr", 32'(addr), 32'(mPc));
      op = curIns[7:4];
      if (op == 4'd8 || (op == 4'd9 && mZ)) mPc = data;
      else mPc = mPc + 8'd1;
      expImm = data;
      expectImm = 1'b0;
    end else begin
      modelRetire();
      checkOutput("fetchAddr", 32'(addr), 32'(mPc));
      modelIssue(data);
    end
  endtask

  // One clock of environment: drive run, watch outputs, answer memory
  task automatic applyStimulus();
    logic [7:0] a;
    run = (runPct >= 100) ? 1'b1 : ($urandom_range(99) < runPct);
    #1;
    if (rf_we) begin
      seenWe++;
      checkOutput("rfRd", 32'(rf_rd), 32'(expRd));
      checkOutput("rfRs", 32'(rf_rs), 32'(curIns[1:0]));
      checkOutput("dinSel", 32'(rf_din_sel), 32'(expSel));
      if (chkOp) checkOutput("aluOp", 32'(alu_op), 32'(expOp));
      if (curIns[7:4] == 4'd7) checkOutput("ldiImm", 32'(imm), 32'(expImm));
    end
    if (illegal) seenIll++;
    if (imem_req) begin
      a = imem_addr;
      if (!pending) begin
        pending = 1'b1;
        pendAddr = a;
        waitLeft = (waitFixed >= 0) ? waitFixed : int'($urandom_range(3));
      end else begin
        checkOutput("addrStable", 32'(a), 32'(pendAddr));
      end
      if (waitLeft == 0) begin
        imem_ack = 1'b1;
        imem_data = mem[a];
        pending = 1'b0;
        handshake(a, mem[a]);
      end else begin
        waitLeft--;
        imem_ack = 1'b0;
        imem_data = 8'($urandom);
      end
    end else begin
      imem_ack = ackNoise ? 1'($urandom_range(1)) : 1'b0;
      imem_data = 8'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    imem_data = 8'h00;
    alu_zero = 1'b0;
    #1;
    checkOutput("rstReq", 32'(imem_req), 32'd0);
    checkOutput("rstWe", 32'(rf_we), 32'd0);
    checkOutput("rstIll", 32'(illegal), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    checkOutput("rstAluOp", 32'(alu_op), 32'd7);
    checkOutput("rstDinSel", 32'(rf_din_sel), 32'd0);
    checkOutput("rstAddr", 32'(imem_addr), 32'(RESET_PC));
    checkOutput("rstZflag", 32'(zflag), 32'd0);
    checkOutput("rstImm", 32'(imm), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mPc = RESET_PC;
    mZ = 1'b0;
    expectImm = 1'b0;
    haveCur = 1'b0;
    pending = 1'b0;
  endtask

  task automatic runUntilHalt(input int maxCycles);
    for (int i = 0; i < maxCycles && !halted; i++) applyStimulus();
    checkOutput("haltReached", 32'(halted), 32'd1);
  endtask

  task automatic checkHalt(input int n);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("haltNoReq", 32'(imem_req), 32'd0);
      checkOutput("haltedHigh", 32'(halted), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic loadProgramA();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    mem[8'h00] = 8'h71; mem[8'h01] = 8'h05;   // LDI R0,5
    mem[8'h02] = 8'h76; mem[8'h03] = 8'h03;   // LDI R1,3
    mem[8'h04] = 8'h11;                       // ADD R0,R1
    mem[8'h05] = 8'h00;                       // NOP
    mem[8'h06] = 8'hB0;                       // illegal
    mem[8'h07] = 8'h64;                       // MOV R1,R0
    mem[8'h08] = 8'h29;                       // SUB R2,R1
    mem[8'h09] = 8'h90; mem[8'h0A] = 8'h40;   // JZ 0x40
  endtask

  initial begin
    int target;
    logic [3:0] rop;
    logic [3:0] rlo;

    $display("[TB] reset and run=0 hold");
    loadProgramA();
    @(negedge clk);
    doReset();
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      imem_data = 8'hAA;
      #1;
      checkOutput("idleNoReq", 32'(imem_req), 32'd0);
      checkOutput("idleAddr", 32'(imem_addr), 32'(RESET_PC));
      @(negedge clk);
    end
    imem_ack = 1'b0;
    run = 1'b1;
    #1;
    checkOutput("firstReq", 32'(imem_req), 32'd1);
    checkOutput("firstAddr", 32'(imem_addr), 32'(RESET_PC));

    $display("[TB] program A, zero flag set, zero-wait");
    waitFixed = 0; runPct = 100; azFixed = 1; latCheck = 1'b1;
    runUntilHalt(200);
    checkOutput("jzTakenPc", 32'(imem_addr), 32'h41);
    checkHalt(20);

    $display("[TB] program A, zero flag clear");
    doReset();
    azFixed = 0;
    runUntilHalt(200);
    checkOutput("jzNotTakenPc", 32'(imem_addr), 32'h0C);
    checkHalt(5);

    $display("[TB] program A, 3-cycle memory waits");
    doReset();
    waitFixed = 3; azFixed = -1; latCheck = 1'b0;
    runUntilHalt(400);
    checkHalt(5);

    $display("[TB] pc wrap through JMP at FF");
    doReset();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    mem[8'h00] = 8'h80; mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h80;
    waitFixed = 0; latCheck = 1'b1;
    runUntilHalt(100);
    checkOutput("wrapHaltPc", 32'(imem_addr), 32'h81);
    checkHalt(5);

    $display("[TB] reset in the middle of FETCH2");
    doReset();
    mem[8'h01] = 8'h20;
    waitFixed = 3; latCheck = 1'b0;
    for (int i = 0; i < 50 && !(expectImm && pending); i++) applyStimulus();
    checkOutput("midFetch2", 32'(expectImm && pending), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", 32'(imem_req), 32'd0);
    checkOutput("midRstPc", 32'(imem_addr), 32'(RESET_PC));
    doReset();
    waitFixed = 0;
    runUntilHalt(100);
    checkOutput("restartHaltPc", 32'(imem_addr), 32'h21);

    $display("[TB] random programs, random waits and run gaps");
    doReset();
    for (int i = 0; i < 256; i++) begin
      rop = 4'($urandom_range(14));
      rlo = 4'($urandom_range(15));
      mem[i] = {rop, rlo};
    end
    waitFixed = -1; runPct = 80; azFixed = -1; ackNoise = 1'b1; latCheck = 1'b0;
    target = nInstr + 300;
    for (int i = 0; i < 15000 && nInstr < target; i++) applyStimulus();
    checkOutput("randProgress", 32'(nInstr >= target), 32'd1);
    checkOutput("randNotHalted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
